// File: rtl/sum_seq_ctrl.sv
// -----------------------------------------------------------------------------
// sum_seq_ctrl
//   Sequences one shared W-bit adder over N chunks to perform a W*N-bit add
//   with carry chaining. Upstream uses a start/busy/done handshake. Operands
//   and carry-in are captured on the accepting edge. One chunk is added per
//   cycle, LSB chunk first.
//
// Ports
//   clk       in   1     clock, rising edge
//   rst       in   1     synchronous reset, active-high
//   start     in   1     request, accepted only in IDLE
//   op_a      in   W*N   operand A
//   op_b      in   W*N   operand B
//   c_in      in   1     carry-in of the full add
//   busy      out  1     high while chunks are being added
//   done      out  1     one-cycle pulse, result valid
//   result    out  W*N   A + B + c_in mod 2^(W*N), held until next accept
//   c_out     out  1     unsigned carry out of the MSB chunk
//   overflow  out  1     signed overflow of the full add
//   add_a     out  W     adder operand a (chunk k of A)
//   add_b     out  W     adder operand b (chunk k of B)
//   add_cin   out  1     adder carry-in
//   add_res   in   W     adder sum (combinational from add_a/add_b/add_cin)
//   add_cout  in   1     adder carry out
// -----------------------------------------------------------------------------
module sum_seq_ctrl #(
   parameter int W = 3,
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [W*N-1:0] op_a,
   input  logic [W*N-1:0] op_b,
   input  logic           c_in,
   output logic           busy,
   output logic           done,
   output logic [W*N-1:0] result,
   output logic           c_out,
   output logic           overflow,
   output logic [W-1:0]   add_a,
   output logic [W-1:0]   add_b,
   output logic           add_cin,
   input  logic [W-1:0]   add_res,
   input  logic           add_cout
);

   localparam int OPW = W * N;
   localparam int KW  = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [KW-1:0]    k_q;
   logic [OPW-1:0]   a_q;
   logic [OPW-1:0]   b_q;
   logic             cin_q;
   logic             carry_q;
   logic [OPW-1:0]   result_q;
   logic [OPW-1:0]   result_d;
   logic             cout_q;
   logic             ovf_q;
   logic             ovf_d;
   logic             busy_q;
   logic             done_q;

   // Adder drive: only the active chunk is presented while running; the
   // adder sees zeros otherwise so it never toggles on stale operands.
   always_comb begin
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
      if (state_q == S_RUN) begin
         add_a   = a_q[k_q*W +: W];
         add_b   = b_q[k_q*W +: W];
         add_cin = (k_q == '0) ? cin_q : carry_q;
      end
   end

   // Next result with the current chunk's sum merged in, and the signed
   // overflow seen when the MSB chunk is summed (same-sign inputs whose
   // sum has the opposite sign).
   always_comb begin
      result_d                = result_q;
      result_d[k_q*W +: W]    = add_res;
      ovf_d = (a_q[OPW-1] == b_q[OPW-1]) && (add_res[W-1] != a_q[OPW-1]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         k_q      <= '0;
         carry_q  <= 1'b0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_q      <= op_a;
                  b_q      <= op_b;
                  cin_q    <= c_in;
                  k_q      <= '0;
                  result_q <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= S_RUN;
               end
            end
            S_RUN: begin
               result_q <= result_d;
               carry_q  <= add_cout;
               k_q      <= k_q + 1'b1;
               if (k_q == K_LAST) begin
                  cout_q  <= add_cout;
                  ovf_q   <= ovf_d;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               // start is deliberately not examined here: requests are
               // never queued, so one arriving now is dropped.
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign result   = result_q;
   assign c_out    = cout_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_sum_seq_ctrl.sv
module tb_sum_seq_ctrl;

   localparam int W   = 3;
   localparam int N   = 4;
   localparam int OPW = W * N;

   logic           clk;
   logic           rst;
   logic           start;
   logic [OPW-1:0] op_a;
   logic [OPW-1:0] op_b;
   logic           c_in;
   logic           busy;
   logic           done;
   logic [OPW-1:0] result;
   logic           c_out;
   logic           overflow;
   logic [W-1:0]   add_a;
   logic [W-1:0]   add_b;
   logic           add_cin;
   logic [W-1:0]   add_res;
   logic           add_cout;

   int checks = 0;
   int errors = 0;

   sum_seq_ctrl #(.W(W), .N(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op_a     (op_a),
      .op_b     (op_b),
      .c_in     (c_in),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .c_out    (c_out),
      .overflow (overflow),
      .add_a    (add_a),
      .add_b    (add_b),
      .add_cin  (add_cin),
      .add_res  (add_res),
      .add_cout (add_cout)
   );

   // The shared W-bit ripple adder the sequencer owns.
   logic [W:0] adder_full;
   assign adder_full = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
   assign add_res    = adder_full[W-1:0];
   assign add_cout   = adder_full[W];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: whole-word arithmetic, no chunking.
   task automatic model(input logic [OPW-1:0] a, input logic [OPW-1:0] b, input logic ci,
                        output logic [OPW-1:0] r, output logic co, output logic ov);
      logic [OPW:0] u;
      int           s;
      u  = {1'b0, a} + {1'b0, b} + {{OPW{1'b0}}, ci};
      r  = u[OPW-1:0];
      co = u[OPW];
      s  = int'($signed(a)) + int'($signed(b)) + int'(ci);
      ov = (s > (2 ** (OPW - 1)) - 1) || (s < -(2 ** (OPW - 1)));
   endtask

   // Issue one add and check latency, handshake and results.
   task automatic run_add(input logic [OPW-1:0] a, input logic [OPW-1:0] b, input logic ci,
                          input string tag);
      logic [OPW-1:0] er;
      logic           eco;
      logic           eov;
      int             cyc;
      int             bcnt;
      model(a, b, ci, er, eco, eov);
      @(negedge clk);
      op_a  = a;
      op_b  = b;
      c_in  = ci;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      // operands may change freely once accepted
      op_a  = OPW'($urandom);
      op_b  = OPW'($urandom);
      c_in  = 1'($urandom);
      cyc   = 1;
      bcnt  = 0;
      while (!done && cyc < 20) begin
         if (busy) bcnt++;
         @(negedge clk);
         cyc++;
      end
      chk({tag, ".done_cycle"}, cyc, N + 1);
      chk({tag, ".busy_cycles"}, bcnt, N);
      chk({tag, ".result"}, result, er);
      chk({tag, ".c_out"}, c_out, eco);
      chk({tag, ".overflow"}, overflow, eov);
      @(negedge clk);
      chk({tag, ".done_pulse"}, done, 1'b0);
      chk({tag, ".held"}, result, er);
      chk({tag, ".idle_add_a"}, add_a, 0);
   endtask

   initial begin
      logic [OPW-1:0] ea;
      logic [OPW-1:0] eb;
      logic [OPW-1:0] er;
      logic           eco;
      logic           eov;
      int             dcnt;
      logic [OPW-1:0] rcap;

      rst   = 1'b1;
      start = 1'b0;
      op_a  = '0;
      op_b  = '0;
      c_in  = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("reset.busy", busy, 0);
      chk("reset.done", done, 0);
      chk("reset.result", result, 0);
      chk("reset.c_out", c_out, 0);
      chk("reset.overflow", overflow, 0);
      chk("reset.add_cin", add_cin, 0);

      run_add(12'h7FF, 12'h001, 1'b0, "max_pos_plus1");
      run_add(12'hFFF, 12'h001, 1'b0, "neg1_plus1");
      run_add(12'h000, 12'h000, 1'b1, "zero_cin");
      run_add(12'h800, 12'h800, 1'b0, "min_plus_min");
      run_add(12'h555, 12'h2AA, 1'b1, "ripple_all");

      // start re-pulsed mid-RUN with other operands: ignored
      model(12'h123, 12'h456, 1'b0, er, eco, eov);
      @(negedge clk);
      op_a = 12'h123; op_b = 12'h456; c_in = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      op_a = 12'hABC; op_b = 12'hDEF; c_in = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      dcnt = 0;
      rcap = '0;
      for (int i = 0; i < 12; i++) begin
         if (done) begin
            dcnt++;
            rcap = result;
         end
         @(negedge clk);
      end
      chk("repulse.done_count", dcnt, 1);
      chk("repulse.result", rcap, er);

      // reset for one cycle while RUN is at k=2
      @(negedge clk);
      op_a = 12'h7FF; op_b = 12'h7FF; c_in = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst.busy", busy, 0);
      chk("midrst.done", done, 0);
      chk("midrst.result", result, 0);
      repeat (6) begin
         @(negedge clk);
         chk("midrst.no_done", done, 0);
      end
      run_add(12'h0F0, 12'h00F, 1'b1, "after_rst");

      // every 3-bit signed pair, sign-extended, both carry-ins
      for (int a = 0; a < 8; a++) begin
         for (int b = 0; b < 8; b++) begin
            for (int c = 0; c < 2; c++) begin
               ea = OPW'(signed'(3'(a)));
               eb = OPW'(signed'(3'(b)));
               ea = {{(OPW-3){ea[2]}}, ea[2:0]};
               eb = {{(OPW-3){eb[2]}}, eb[2:0]};
               run_add(ea, eb, 1'(c), "small");
            end
         end
      end

      // random full-width operands
      repeat (40) begin
         ea = OPW'($urandom);
         eb = OPW'($urandom);
         run_add(ea, eb, 1'($urandom), "random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
